uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive control unit for the serial UART datapath. It sits downstream of the start-bit detector and sequences one frame per detected start bit. For each frame it times mid-bit sampling with an internal bit timer, qualifies the start bit, shifts in the data bits LSB-first and checks the stop bit. It then presents the byte to the consumer with a ready/read handshake and flags framing and overrun errors.

## Interface
- CLKS_PER_BIT, default 10: clock cycles per serial bit; legal range 4..255.
- DATA_BITS, default 8: data bits per frame; legal range 5..8.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start_bit_detected  in  1  falling-edge pulse from the start-bit detector; ignored unless in IDLE.
- serial_in  in  1  synchronized serial line; idle value 1.
- data_read  in  1  consumer has taken rx_data; single-cycle pulse.
- rx_data  out  DATA_BITS  last correctly framed byte.
- data_ready  out  1  rx_data holds an unread byte.
- overrun_error  out  1  an unread byte was overwritten.
- framing_error  out  1  the last frame had stop bit = 0.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE to START: on start_bit_detected=1. The bit timer is loaded and framing_error is cleared.
- START: at the half-bit strobe, sample serial_in.
  - If 1, it is a false start: go to IDLE, no flags change.
  - If 0, go to DATA with bit index 0.
- DATA: at each full-bit strobe, shift serial_in into the shift register MSB-side, so that after DATA_BITS shifts bit 0 is the first received bit.
  - The bit index increments on each strobe.
  - After DATA_BITS samples, go to STOP.
- STOP: at the full-bit strobe, sample serial_in, then go to IDLE.
  - Stop bit = 1: rx_data ← shift register and data_ready ← 1.
  - If data_ready was already 1 and data_read is not asserted in that same cycle, overrun_error ← 1.
  - Stop bit = 0: framing_error ← 1; rx_data and data_ready are unchanged and the frame is discarded.
- data_read=1 clears data_ready and overrun_error on the next edge.
- Simultaneous data_read and load: the load wins. data_ready stays 1 and overrun_error is not set.
- framing_error is sticky until the next accepted start (IDLE→START transition) or rst.
- Reset, including mid-frame: state=IDLE, timer/index/shift register=0, all outputs 0; the partial frame is lost.

## Timing
- T = the cycle in which start_bit_detected=1 is seen in IDLE. HALF = CLKS_PER_BIT/2, truncated.
- Start sample: cycle T+HALF.
- Data bit k (0-based) sample: cycle T+HALF+(k+1)·CLKS_PER_BIT.
- Stop sample: cycle S = T+HALF+(DATA_BITS+1)·CLKS_PER_BIT.
- data_ready, rx_data, framing_error and overrun_error are registered and visible at S+1. State is IDLE at S+1.
- A start_bit_detected arriving at S+1 is accepted, giving back-to-back frames.
- busy rises at T+1 and falls at S+1, or at T+HALF+1 on a false start.
- Bit timer width: $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on the strobe.
- Bit index width: $clog2(DATA_BITS+1).

## Structure
- Package uart_rx_pkg holds:
  - typedef enum logic [1:0] rx_state_t {IDLE, START, DATA, STOP};
  - default constants UART_CLKS_PER_BIT=10 and UART_DATA_BITS=8.
- Sub-module rx_bit_timer (clk, rst, load, half, strobe):
  - load restarts the count.
  - half=1 selects a HALF-cycle interval for the first strobe; subsequent strobes occur every CLKS_PER_BIT cycles.
  - strobe is a single-cycle pulse.
- The FSM, shift register, bit index and output registers live in uart_rx_ctrl.

## Test plan
- Good frame, CLKS_PER_BIT=10, DATA_BITS=8, byte 0xA5, stop=1 → rx_data=8'hA5 and data_ready=1 at S+1; framing_error=0, overrun_error=0. data_read → data_ready=0 next cycle.
- False start: line low for 3 cycles, then high → busy drops at T+6, data_ready stays 0, framing_error stays 0.
- Framing error: byte 0x3C with stop=0 → framing_error=1 at S+1, data_ready=0. The next good frame 0x11 clears framing_error at its T+1 and loads 8'h11.
- Overrun: frames 0x3C then 0xC3 back-to-back with no data_read → rx_data=8'hC3, data_ready=1, overrun_error=1. data_read clears both flags.
- Read/load collision: data_read pulsed exactly at cycle S of the second frame → rx_data=new byte, data_ready=1, overrun_error=0.
- Reset mid-frame: rst asserted during data bit 4 → next cycle busy=0, all outputs 0. A following full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and default frame parameters for the UART receive path.
package uart_rx_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

   localparam int UART_CLKS_PER_BIT = 10;
   localparam int UART_DATA_BITS    = 8;

endpackage

// File: rtl/uart_rx_ctrl_timer.sv
// Mid-bit sampling timer: first strobe after a half bit when requested,
// then one single-cycle strobe every CLKS_PER_BIT cycles.
module rx_bit_timer #(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic half,
   output logic strobe
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          half_q, half_d;

   always_comb begin
      cnt_d  = cnt_q + CW'(1);
      half_d = half_q;
      strobe = half_q ? (cnt_q == HALF_LAST) : (cnt_q == FULL_LAST);
      if (load) begin
         cnt_d  = '0;
         half_d = half;
      end else if (strobe) begin
         // Half interval applies only to the first strobe after a load.
         cnt_d  = '0;
         half_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         half_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         half_q <= half_d;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: qualifies the start bit, shifts data LSB-first,
// checks the stop bit and hands the byte over with ready/read and error flags.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int DATA_BITS    = UART_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_bit_detected,
   input  logic                 serial_in,
   input  logic                 data_read,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 data_ready,
   output logic                 overrun_error,
   output logic                 framing_error,
   output logic                 busy
);

   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

   rx_state_t            state_q, state_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 ready_q, ready_d;
   logic                 overrun_q, overrun_d;
   logic                 framing_q, framing_d;
   logic                 timer_load;
   logic                 strobe;

   rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load   (timer_load),
      .half   (1'b1),
      .strobe (strobe)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      rx_data_d  = rx_data_q;
      ready_d    = ready_q;
      overrun_d  = overrun_q;
      framing_d  = framing_q;
      timer_load = 1'b0;

      if (data_read) begin
         ready_d   = 1'b0;
         overrun_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (start_bit_detected) begin
               state_d    = START;
               timer_load = 1'b1;
               framing_d  = 1'b0;
            end
         end
         START: begin
            if (strobe) begin
               state_d = serial_in ? IDLE : DATA;
               idx_d   = '0;
            end
         end
         DATA: begin
            if (strobe) begin
               shift_d = {serial_in, shift_q[DATA_BITS-1:1]};
               idx_d   = idx_q + IW'(1);
               if (idx_q == LAST_IDX) state_d = STOP;
            end
         end
         STOP: begin
            if (strobe) begin
               state_d = IDLE;
               if (serial_in) begin
                  // A load in the same cycle as a read wins over the read.
                  rx_data_d = shift_q;
                  ready_d   = 1'b1;
                  overrun_d = overrun_d | (ready_q & ~data_read);
               end else begin
                  framing_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         shift_q   <= '0;
         rx_data_q <= '0;
         ready_q   <= 1'b0;
         overrun_q <= 1'b0;
         framing_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         rx_data_q <= rx_data_d;
         ready_q   <= ready_d;
         overrun_q <= overrun_d;
         framing_q <= framing_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign data_ready    = ready_q;
   assign overrun_error = overrun_q;
   assign framing_error = framing_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 10 clocks/bit, 8 data bits.
module tb_uart_rx_ctrl;

   localparam int C     = 10;
   localparam int DB    = 8;
   localparam int HALF  = C / 2;
   localparam int S_OFF = HALF + (DB + 1) * C;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start_bit_detected = 1'b0;
   logic          serial_in = 1'b1;
   logic          data_read = 1'b0;
   logic [DB-1:0] rx_data;
   logic          data_ready, overrun_error, framing_error, busy;

   int checks   = 0;
   int failures = 0;

   uart_rx_ctrl #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (
      .clk                (clk),
      .rst                (rst),
      .start_bit_detected (start_bit_detected),
      .serial_in          (serial_in),
      .data_read          (data_read),
      .rx_data            (rx_data),
      .data_ready         (data_ready),
      .overrun_error      (overrun_error),
      .framing_error      (framing_error),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Serial line level at n cycles after the start was accepted.
   function automatic logic line_bit(input logic [7:0] b, input logic stop, input int n);
      int j;
      j = n / C;
      if (j == 0) return 1'b0;
      if (j <= DB) return b[j-1];
      return stop;
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic stop, input bit read_at_s);
      start_bit_detected = 1'b1;
      serial_in          = 1'b0;
      tick();
      start_bit_detected = 1'b0;
      check("busy_rise", busy, 1);
      check("fe_clear_at_t1", framing_error, 0);
      for (int n = 1; n <= S_OFF; n++) begin
         serial_in = line_bit(b, stop, n);
         data_read = read_at_s && (n == S_OFF);
         tick();
      end
      serial_in = 1'b1;
      data_read = 1'b0;
      check("busy_fall", busy, 0);
   endtask

   task automatic read_pulse();
      data_read = 1'b1;
      tick();
      data_read = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) tick();
      check("rst_rx_data", rx_data, 0);
      check("rst_ready", data_ready, 0);
      check("rst_overrun", overrun_error, 0);
      check("rst_framing", framing_error, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      repeat (2) tick();

      // Good frame
      send_frame(8'hA5, 1'b1, 1'b0);
      check("good_rx_data", rx_data, 8'hA5);
      check("good_ready", data_ready, 1);
      check("good_framing", framing_error, 0);
      check("good_overrun", overrun_error, 0);
      read_pulse();
      check("good_read_clears", data_ready, 0);
      repeat (3) tick();

      // False start: line low for 3 cycles, then high before the mid-bit sample
      start_bit_detected = 1'b1;
      serial_in          = 1'b0;
      tick();
      start_bit_detected = 1'b0;
      check("fs_busy_rise", busy, 1);
      for (int n = 1; n <= HALF; n++) begin
         serial_in = (n < 3) ? 1'b0 : 1'b1;
         if (n == HALF) check("fs_busy_t5", busy, 1);
         tick();
      end
      check("fs_busy_t6", busy, 0);
      check("fs_ready", data_ready, 0);
      check("fs_framing", framing_error, 0);
      repeat (3) tick();

      // Framing error followed by a good frame
      send_frame(8'h3C, 1'b0, 1'b0);
      check("fe_set", framing_error, 1);
      check("fe_ready", data_ready, 0);
      check("fe_rx_data_kept", rx_data, 8'hA5);
      send_frame(8'h11, 1'b1, 1'b0);
      check("fe_next_rx_data", rx_data, 8'h11);
      check("fe_next_ready", data_ready, 1);
      check("fe_next_framing", framing_error, 0);
      read_pulse();
      check("fe_next_read", data_ready, 0);

      // Overrun: back-to-back frames, no read
      send_frame(8'h3C, 1'b1, 1'b0);
      check("ov_first_overrun", overrun_error, 0);
      send_frame(8'hC3, 1'b1, 1'b0);
      check("ov_rx_data", rx_data, 8'hC3);
      check("ov_ready", data_ready, 1);
      check("ov_overrun", overrun_error, 1);
      read_pulse();
      check("ov_read_ready", data_ready, 0);
      check("ov_read_overrun", overrun_error, 0);

      // Read coinciding with the load of the second frame
      send_frame(8'h3C, 1'b1, 1'b0);
      send_frame(8'h96, 1'b1, 1'b1);
      check("col_rx_data", rx_data, 8'h96);
      check("col_ready", data_ready, 1);
      check("col_overrun", overrun_error, 0);

      // Reset during data bit 4 with a byte still pending
      start_bit_detected = 1'b1;
      serial_in          = 1'b0;
      tick();
      start_bit_detected = 1'b0;
      for (int n = 1; n <= 5 * C + 2; n++) begin
         serial_in = line_bit(8'hFF, 1'b1, n);
         tick();
      end
      check("mid_busy_before_rst", busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      serial_in = 1'b1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rx_data", rx_data, 0);
      check("mid_rst_ready", data_ready, 0);
      check("mid_rst_overrun", overrun_error, 0);
      check("mid_rst_framing", framing_error, 0);
      repeat (2) tick();
      send_frame(8'h5A, 1'b1, 1'b0);
      check("post_rst_rx_data", rx_data, 8'h5A);
      check("post_rst_ready", data_ready, 1);
      check("post_rst_overrun", overrun_error, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
